// File: rtl/step_addr_counter_if.sv
// step_addr_counter_if: control/status bundle for step_addr_counter.
//   EN, CLR, LOAD, LOAD_VAL, DIR, SAT, LIMIT : sequencer -> counter
//   OUT, STEP, TC, DONE                      : counter -> sequencer
//   OUT_GRAY                                 : counter -> sequencer, only with
//                                              STEP_ADDR_COUNTER_GRAY_EN defined
// master = sequencer side, slave = counter side.
interface step_addr_counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             EN;
    logic             CLR;
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_VAL;
    logic             DIR;
    logic             SAT;
    logic [WIDTH-1:0] LIMIT;
    logic [WIDTH-1:0] OUT;
    logic             STEP;
    logic             TC;
    logic             DONE;
`ifdef STEP_ADDR_COUNTER_GRAY_EN
    logic [WIDTH-1:0] OUT_GRAY;

    modport master (
        output EN, CLR, LOAD, LOAD_VAL, DIR, SAT, LIMIT,
        input  OUT, STEP, TC, DONE, OUT_GRAY
    );
    modport slave (
        input  EN, CLR, LOAD, LOAD_VAL, DIR, SAT, LIMIT,
        output OUT, STEP, TC, DONE, OUT_GRAY
    );
`else
    modport master (
        output EN, CLR, LOAD, LOAD_VAL, DIR, SAT, LIMIT,
        input  OUT, STEP, TC, DONE
    );
    modport slave (
        input  EN, CLR, LOAD, LOAD_VAL, DIR, SAT, LIMIT,
        output OUT, STEP, TC, DONE
    );
`endif
endinterface

// File: rtl/step_addr_counter.sv
// step_addr_counter: prescaled up/down address counter for march/repair sweeps.
// While EN is high, OUT steps once after FIRST_DIV enabled edges, then once
// every STEP_DIV enabled edges. Terminal value is LIMIT counting up and 0
// counting down; at the terminal OUT wraps (SAT=0) or holds (SAT=1).
// Ports:
//   CLK  : clock, rising edge
//   RSTN : asynchronous active-low reset
//   bus  : step_addr_counter_if.slave (EN/CLR/LOAD/LOAD_VAL/DIR/SAT/LIMIT in,
//          OUT/STEP/TC/DONE out)
// Optional feature macro STEP_ADDR_COUNTER_GRAY_EN adds bus.OUT_GRAY, the
// Gray code of OUT, registered on the same edge as OUT.
module step_addr_counter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FIRST_DIV = 5,
    parameter int unsigned STEP_DIV  = 4
) (
    input logic              CLK,
    input logic              RSTN,
    step_addr_counter_if.slave bus
);
    localparam int unsigned DIV_MAX = (FIRST_DIV > STEP_DIV) ? FIRST_DIV : STEP_DIV;
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [DIV_W-1:0] FIRST_LAST = DIV_W'(FIRST_DIV - 1);
    localparam logic [DIV_W-1:0] STEP_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);
    localparam logic [WIDTH-1:0] OUT_ONE    = WIDTH'(1);

    typedef enum logic [0:0] {PhFirst, PhRun} phase_e;

    phase_e           phase_q;
    logic [DIV_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_q;
    logic             step_q;
    logic             tc_q;
    logic             done_q;

    logic             step_evt;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] step_val;
    logic             step_pulse;
    logic             tc_pulse;

    // Result of a step event; only committed when step_evt fires.
    always_comb begin
        step_evt   = bus.EN && (((phase_q == PhFirst) && (cnt_q == FIRST_LAST)) ||
                                ((phase_q == PhRun)   && (cnt_q == STEP_LAST)));
        term       = bus.DIR ? '0 : bus.LIMIT;
        step_val   = out_q;
        step_pulse = 1'b0;
        tc_pulse   = 1'b0;
        if (out_q != term) begin
            step_val   = bus.DIR ? (out_q - OUT_ONE) : (out_q + OUT_ONE);
            step_pulse = 1'b1;
            tc_pulse   = (step_val == term);
        end else if (!bus.SAT) begin
            // Wrap lands on the far end; not a terminal hit.
            step_val   = bus.DIR ? bus.LIMIT : '0;
            step_pulse = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            phase_q <= PhFirst;
            cnt_q   <= '0;
            out_q   <= '0;
            step_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.CLR) begin
            phase_q <= PhFirst;
            cnt_q   <= '0;
            out_q   <= '0;
            step_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.LOAD) begin
            phase_q <= PhFirst;
            cnt_q   <= '0;
            out_q   <= bus.LOAD_VAL;
            step_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (!bus.EN) begin
            phase_q <= PhFirst;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else if (step_evt) begin
            // Prescaler keeps running even when a saturated step holds OUT.
            phase_q <= PhRun;
            cnt_q   <= '0;
            out_q   <= step_val;
            step_q  <= step_pulse;
            tc_q    <= tc_pulse;
            done_q  <= done_q | tc_pulse;
        end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            step_q  <= 1'b0;
            tc_q    <= 1'b0;
        end
    end

    assign bus.OUT  = out_q;
    assign bus.STEP = step_q;
    assign bus.TC   = tc_q;
    assign bus.DONE = done_q;

`ifdef STEP_ADDR_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] out_d;

    // Mirror of the OUT next-state so the Gray register updates on the same edge.
    always_comb begin
        out_d = out_q;
        if (bus.CLR) begin
            out_d = '0;
        end else if (bus.LOAD) begin
            out_d = bus.LOAD_VAL;
        end else if (step_evt) begin
            out_d = step_val;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            gray_q <= '0;
        end else begin
            gray_q <= out_d ^ (out_d >> 1);
        end
    end

    assign bus.OUT_GRAY = gray_q;
`else
    // Gray output absent in this build.
`endif
endmodule

// File: doc/step_addr_counter.md
Name: step_addr_counter

Overview:
- Parametrised, prescaled address/step counter for the memory-controller and BISR sequencers.
- While enabled, it advances its output once after a programmable first-step delay, then once every programmable step period.
- Adds width/delay parametrisation, up/down direction, load, synchronous clear, a programmable terminal value with wrap or saturate, and step/terminal flags.
- Drives address generation for march/repair sweeps.

Parameters:
- WIDTH, 16, counter output width in bits.
- FIRST_DIV, 5, enabled clock edges from enable start (or LOAD/CLR) to the first step; legal range 1 or more.
- STEP_DIV, 4, enabled clock edges between later steps; legal range 1 or more.
- Derived localparam DIV_W = clog2(max(FIRST_DIV,STEP_DIV)); minimum 1. Not overridable.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- EN  input  1  count enable; low resets the prescaler phase only.
- CLR  input  1  synchronous clear, highest priority.
- LOAD  input  1  synchronous load of LOAD_VAL.
- LOAD_VAL  input  WIDTH  load value.
- DIR  input  1  0 = count up, 1 = count down.
- SAT  input  1  1 = hold at terminal, 0 = wrap.
- LIMIT  input  WIDTH  terminal value for up counting; wrap target for down counting.
- OUT  output  WIDTH  registered count.
- STEP  output  1  one-cycle pulse on each edge where OUT changes due to a step.
- TC  output  1  one-cycle pulse on the edge where a step lands on the terminal value.
- DONE  output  1  sticky terminal-reached flag.

Behaviour:
- Reset (async, RSTN=0): OUT=0, STEP=0, TC=0, DONE=0, prescaler count=0, phase=FIRST.
- Prescaler phases:
  - FIRST: a step event occurs on the FIRST_DIV-th consecutive edge with EN=1, then phase becomes RUN and count=0.
  - RUN: a step event occurs every STEP_DIV-th edge with EN=1.
  - Defaults: steps at enabled edges 5, 9, 13, ...
- EN=0 at an edge: count=0, phase=FIRST; OUT and DONE hold; STEP=TC=0.
- Priority per edge: CLR > LOAD > step event.
  - CLR: OUT=0, DONE=0, prescaler to FIRST/0, STEP=TC=0. Applies regardless of EN.
  - LOAD: OUT=LOAD_VAL, DONE=0, prescaler to FIRST/0, STEP=TC=0. Applies regardless of EN.
- Terminal value: LIMIT when DIR=0; 0 when DIR=1.
- Step event, OUT != terminal:
  - DIR=0: OUT+1, modulo 2^WIDTH. If OUT>LIMIT it rolls through 2^WIDTH-1 to 0 and up to LIMIT.
  - DIR=1: OUT-1.
  - STEP=1. If the new OUT equals the terminal: TC=1, DONE=1.
- Step event, OUT == terminal:
  - SAT=0: OUT wraps (DIR=0 to 0; DIR=1 to LIMIT); STEP=1; TC=0.
  - SAT=1: OUT holds; STEP=0, TC=0; prescaler keeps running.
- DIR, SAT and LIMIT are sampled at each step edge. Changing them mid-run does not reset the prescaler.
- Terminal compare uses the LIMIT value present at the step edge.
- STEP/TC are registered and coincide with the edge on which OUT updates; latency from a step event to visible OUT is 0 extra cycles.
- FIRST_DIV=1 and STEP_DIV=1: one step per enabled cycle starting on the first enabled edge.
- DONE is cleared only by reset, CLR or LOAD.

Optional Feature:
- Macro STEP_ADDR_COUNTER_GRAY_EN.
- Defined: adds output port OUT_GRAY (WIDTH), a registered Gray code of the next OUT, updated on the same edge as OUT (OUT_GRAY == OUT ^ (OUT>>1) at all times). Reset value is 0.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Defaults, LIMIT=16'hFFFF, DIR=0, EN=1 from edge 1 -> OUT=1 at edge 5, 2 at edge 9, 3 at edge 13; STEP high only on those edges; TC=DONE=0.
- EN low for 2 cycles after edge 7, then high again -> OUT stays 1, prescaler restarts; next OUT=2 on the 5th enabled edge after re-enable.
- LIMIT=3, SAT=0, DIR=0 -> OUT 1,2,3 (TC pulse, DONE=1),0,1. Rerun with SAT=1 -> OUT holds 3, no further STEP, DONE stays 1.
- LOAD_VAL=2, DIR=1, LIMIT=5, SAT=0 -> OUT 2 (first step 5 edges after LOAD),1,0 (TC),5,4.
- CLR and LOAD asserted on a step edge with OUT=7 -> OUT=0, DONE=0, no STEP; next step FIRST_DIV enabled edges later. Async RSTN mid-run -> all outputs 0 immediately.
- With STEP_ADDR_COUNTER_GRAY_EN: OUT 0..7 -> OUT_GRAY 0,1,3,2,6,7,5,4, always matching OUT on the same edge.
